// File: rtl/row_matmul_scheduler.sv
// Credit-based row scheduler: issues rows to a multiply datapath and re-orders nothing,
// buffering in-order results in a small FIFO so a returning result always has a slot.
module row_matmul_scheduler #(
    parameter int W     = 16,
    parameter int DEPTH = 4,
    parameter int CW    = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_v,
    output logic                  in_ready,
    input  logic signed [W-1:0]   in_d0,
    input  logic signed [W-1:0]   in_d1,
    input  logic signed [W-1:0]   in_d2,
    input  logic signed [W-1:0]   in_d3,
    output logic                  mm_v,
    output logic signed [W-1:0]   mm_a_d0,
    output logic signed [W-1:0]   mm_a_d1,
    output logic signed [W-1:0]   mm_a_d2,
    output logic signed [W-1:0]   mm_a_d3,
    input  logic                  mm_out_v,
    input  logic signed [2*W-1:0] mm_out_d0,
    input  logic signed [2*W-1:0] mm_out_d1,
    input  logic signed [2*W-1:0] mm_out_d2,
    input  logic signed [2*W-1:0] mm_out_d3,
    output logic                  out_v,
    input  logic                  out_ready,
    output logic signed [2*W-1:0] out_d0,
    output logic signed [2*W-1:0] out_d1,
    output logic signed [2*W-1:0] out_d2,
    output logic signed [2*W-1:0] out_d3,
    input  logic                  flush,
    output logic                  flush_done,
    output logic                  busy,
    output logic                  err_unexp
);

    localparam int             PW        = $clog2(DEPTH);
    localparam logic [CW:0]    DEPTH_SUM = (CW+1)'(DEPTH);
    localparam logic [PW-1:0]  LAST_PTR  = PW'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t          state;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   occupancy;
    logic [CW-1:0]   inflight_nxt;
    logic [CW-1:0]   occupancy_nxt;
    logic [CW:0]     credit_sum;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [8*W-1:0]  mem [DEPTH];
    logic [8*W-1:0]  out_row;
    logic            issue;
    logic            ret_ok;
    logic            ret_bad;
    logic            pop;
    logic            drained;

    // Every accepted row reserves a FIFO slot until its result leaves downstream.
    assign credit_sum = {1'b0, inflight} + {1'b0, occupancy};
    assign in_ready   = ((state == IDLE) || (state == RUN)) && (credit_sum < DEPTH_SUM);

    assign mm_v    = in_v && in_ready && rst;
    assign mm_a_d0 = in_d0;
    assign mm_a_d1 = in_d1;
    assign mm_a_d2 = in_d2;
    assign mm_a_d3 = in_d3;

    assign issue   = mm_v;
    assign ret_ok  = mm_out_v && (inflight != '0);
    assign ret_bad = mm_out_v && (inflight == '0);
    assign out_v   = (occupancy != '0);
    assign pop     = out_v && out_ready;

    // The head is forced to zero when empty so stale entries never leak after reset.
    assign out_row = out_v ? mem[rd_ptr] : '0;
    assign out_d0  = out_row[0*2*W +: 2*W];
    assign out_d1  = out_row[1*2*W +: 2*W];
    assign out_d2  = out_row[2*2*W +: 2*W];
    assign out_d3  = out_row[3*2*W +: 2*W];

    assign busy = (state != IDLE);

    always_comb begin
        inflight_nxt  = inflight;
        occupancy_nxt = occupancy;
        case ({issue, ret_ok})
            2'b10:   inflight_nxt = inflight + 1'b1;
            2'b01:   inflight_nxt = inflight - 1'b1;
            default: inflight_nxt = inflight;
        endcase
        case ({ret_ok, pop})
            2'b10:   occupancy_nxt = occupancy + 1'b1;
            2'b01:   occupancy_nxt = occupancy - 1'b1;
            default: occupancy_nxt = occupancy;
        endcase
    end

    assign drained = (inflight_nxt == '0) && (occupancy_nxt == '0);

    always_ff @(posedge clk) begin
        if (ret_ok) begin
            mem[wr_ptr] <= {mm_out_d3, mm_out_d2, mm_out_d1, mm_out_d0};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            inflight   <= '0;
            occupancy  <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            flush_done <= 1'b0;
            err_unexp  <= 1'b0;
        end else begin
            inflight   <= inflight_nxt;
            occupancy  <= occupancy_nxt;
            flush_done <= 1'b0;
            if (ret_ok) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            if (ret_bad) begin
                err_unexp <= 1'b1;
            end
            // A flush that finds nothing outstanding completes straight away.
            case (state)
                IDLE: begin
                    if (flush && drained) begin
                        flush_done <= 1'b1;
                    end else if (flush) begin
                        state <= DRAIN;
                    end else if (issue) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (flush && drained) begin
                        state      <= IDLE;
                        flush_done <= 1'b1;
                    end else if (flush) begin
                        state <= DRAIN;
                    end else if (drained) begin
                        state <= IDLE;
                    end
                end
                DRAIN: begin
                    if (drained) begin
                        state      <= IDLE;
                        flush_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/row_matmul_scheduler.md
ROW_MATMUL_SCHEDULER -- requirements
Module: row_matmul_scheduler

Interface
REQ-001 SHALL have parameter W, default 16, operand element width.
REQ-002 SHALL have parameter DEPTH, default 4, result FIFO depth; legal values 2..16.
REQ-003 SHALL have parameter CW, default 5, width of the in-flight and occupancy counters; CW >= log2(DEPTH)+1.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port in_v, input, 1 bit: an input row is offered.
REQ-007 SHALL have port in_ready, output, 1 bit: the scheduler accepts the offered row this cycle.
REQ-008 SHALL have ports in_d0..in_d3, input, W bits each: signed row elements.
REQ-009 SHALL have port mm_v, output, 1 bit: the row on mm_a_* is issued to the multiply datapath this cycle.
REQ-010 SHALL have ports mm_a_d0..mm_a_d3, output, W bits each: signed row elements driven to the datapath.
REQ-011 SHALL have port mm_out_v, input, 1 bit: datapath result valid, exactly one per issued row, in issue order.
REQ-012 SHALL have ports mm_out_d0..mm_out_d3, input, 2W bits each: signed datapath results.
REQ-013 SHALL have port out_v, output, 1 bit: a result row is presented.
REQ-014 SHALL have port out_ready, input, 1 bit: downstream accepts the presented row.
REQ-015 SHALL have ports out_d0..out_d3, output, 2W bits each: signed result row, FIFO head.
REQ-016 SHALL have port flush, input, 1 bit: single-cycle drain request.
REQ-017 SHALL have port flush_done, output, 1 bit: one-cycle pulse when the drain completes.
REQ-018 SHALL have port busy, output, 1 bit: state is not IDLE.
REQ-019 SHALL have port err_unexp, output, 1 bit: sticky flag for mm_out_v received with zero rows in flight.

Function
REQ-020 SHALL accept a row when in_v && in_ready; a row is issued on the same cycle (mm_v=1, mm_a_*=in_d*, combinational pass-through).
REQ-021 SHALL use credits: in_ready = (state==RUN or state==IDLE) && (inflight + occupancy < DEPTH), so a result always finds a free FIFO slot.
REQ-022 SHALL increment inflight on issue, decrement on mm_out_v; simultaneous issue and return leave it unchanged.
REQ-023 SHALL write mm_out_d* into the FIFO on mm_out_v; occupancy increments on write, decrements on out_v && out_ready, and is unchanged when both occur.
REQ-024 SHALL implement the FIFO with wrap-around read/write pointers modulo DEPTH; out_v = (occupancy != 0); out_d* = entry at the read pointer.
REQ-025 SHALL, when the FIFO is empty, not bypass: a result written in cycle N appears on out_v in cycle N+1.
REQ-026 SHALL hold out_d* stable while out_v && !out_ready.
REQ-027 SHALL have states IDLE, RUN, DRAIN; IDLE->RUN on issue; RUN->IDLE when inflight==0 and occupancy==0 after the update; any state->DRAIN on flush.
REQ-028 SHALL, in DRAIN, deassert in_ready, keep returning and emitting results, and go to IDLE pulsing flush_done for one cycle once inflight==0 and occupancy==0.
REQ-029 SHALL, on flush received while already empty, pulse flush_done the following cycle and return to IDLE.
REQ-030 SHALL ignore flush asserted while in DRAIN; it does not extend the drain or cause a second pulse.
REQ-031 SHALL, on mm_out_v with inflight==0, set err_unexp, discard the data, and leave the counters unchanged.
REQ-032 SHALL keep inflight, occupancy and pointers saturating-free; CW overflow is impossible under REQ-021.

Reset
REQ-033 SHALL, on rst low, immediately clear state to IDLE, inflight, occupancy and pointers to 0, and drive in_ready=1, mm_v=0, out_v=0, out_d*=0, flush_done=0, busy=0, err_unexp=0.
REQ-034 SHALL, on reset asserted mid-operation, discard all in-flight and buffered results; returning mm_out_v after release sets err_unexp.
REQ-035 SHALL treat reset release as synchronous to clk (external synchronizer).

Verification
REQ-036 SHALL pass single row: in_d=(1,2,3,4) accepted at cycle 0 with mm_v=1; mm_out_v at cycle 3 with (10,20,30,40) -> out_v=1 at cycle 4 with out_d=(10,20,30,40); busy drops after the out_ready handshake.
REQ-037 SHALL pass credit limit: DEPTH=4, out_ready=0, in_v held -> exactly 4 rows accepted, in_ready=0 afterwards, occupancy reaches 4, and no row is lost.
REQ-038 SHALL pass wrap-around: 10 rows streamed with out_ready toggling 1,0 -> 10 outputs emitted in issue order, values intact.
REQ-039 SHALL pass flush: 3 rows in flight, flush pulsed -> in_ready=0 immediately, all 3 results emitted, then flush_done is a single pulse and busy=0.
REQ-040 SHALL pass error path: mm_out_v injected with nothing in flight -> err_unexp=1, out_v stays 0; cleared only by rst.
REQ-041 SHALL pass mid-reset: rst pulsed low with 2 rows in FIFO -> out_v=0 at once and in_ready=1 after release.
